// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULTU, DIVU, MTHI, MTLO).
// Define SIGNED_MULDIV_EN to add the signed_op port and two's-complement MULT/DIV.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
`ifdef SIGNED_MULDIV_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    typedef enum logic [1:0] {OP_MULTU = 2'd0, OP_DIVU = 2'd1, OP_MTHI = 2'd2, OP_MTLO = 2'd3} op_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opa;      // multiplicand (MUL) or dividend shifting into quotient (DIV)
    logic [WIDTH-1:0]   opb;      // multiplier shifting right (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic               accept, last, div_zero;
    logic [WIDTH-1:0]   mag_x, mag_y;

    assign accept   = start && (state != RUN);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign div_zero = op[0] && (y == '0);

`ifdef SIGNED_MULDIV_EN
    logic neg_x, neg_y, neg_q, neg_r;
    assign neg_x = signed_op && x[WIDTH-1];
    assign neg_y = signed_op && y[WIDTH-1];
    assign mag_x = neg_x ? -x : x;
    assign mag_y = neg_y ? -y : y;
`else
    assign mag_x = x;
    assign mag_y = y;
`endif

    // Shift-add step: add the multiplicand into the upper half, then shift the whole product right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    assign acc_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring division step; the shifted partial remainder needs one extra bit.
    logic [WIDTH:0]   rem_shift;
    logic             div_fit;
    logic [WIDTH-1:0] rem_step, quo_step;
    assign rem_shift = {rem, opa[WIDTH-1]};
    assign div_fit   = (rem_shift >= {1'b0, opb});
    assign rem_step  = div_fit ? WIDTH'(rem_shift - {1'b0, opb}) : rem_shift[WIDTH-1:0];
    assign quo_step  = {opa[WIDTH-2:0], div_fit};

    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0]   quo_res, rem_res;
`ifdef SIGNED_MULDIV_EN
    assign prod_res = neg_q ? -acc_step : acc_step;
    assign quo_res  = neg_q ? -quo_step : quo_step;
    assign rem_res  = neg_r ? -rem_step : rem_step;
`else
    assign prod_res = acc_step;
    assign quo_res  = quo_step;
    assign rem_res  = rem_step;
`endif

    // NOTE: state_next gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FINISH: begin
                state_next = IDLE;
                if (start && !op[1])
                    state_next = div_zero ? FINISH : RUN;
            end
            RUN:     if (last) state_next = FINISH;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            rem    <= '0;
            hi     <= '0;
            lo     <= '0;
`ifdef SIGNED_MULDIV_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                case (op_t'(op))
                    OP_MTHI: hi <= x;
                    OP_MTLO: lo <= x;
                    default: begin
                        is_div <= op[0];
                        cnt    <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        opa    <= mag_x;
                        opb    <= mag_y;
`ifdef SIGNED_MULDIV_EN
                        neg_q  <= neg_x ^ neg_y;
                        neg_r  <= neg_x;
`endif
                        if (div_zero) begin
                            hi <= x;
                            lo <= '1;
                        end
                    end
                endcase
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    rem <= rem_step;
                    opa <= quo_step;
                end else begin
                    acc <= acc_step;
                    opb <= opb >> 1;
                end
                // Final step writes straight into HI/LO so the result is visible in FINISH.
                if (last) begin
                    if (is_div) begin
                        hi <= rem_res;
                        lo <= quo_res;
                    end else begin
                        {hi, lo} <= prod_res;
                    end
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        sgn = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .x         (x),
        .y         (y),
`ifdef SIGNED_MULDIV_EN
        .signed_op (sgn),
`endif
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} computed from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        int     sa, sb, q, r;
        longint p;
        sa = a;
        sb = b;
        if (o == 2'd0) begin
            if (s) begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1;
        op    = o;
        x     = a;
        y     = b;
        sgn   = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; leaves the bench at the negedge where done=1.
    task automatic finish_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input string tag, input int inject);
        logic [63:0] r;
        int nb;
        nb = 0;
        while (busy === 1'b1 && nb < 64) begin
            check({tag, "_hold"}, {hi, lo}, {hi_m, lo_m});
            nb++;
            if (nb == inject) begin
                start = 1'b1;
                op    = 2'd3;
                x     = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, nb, (o == 2'd1 && b == 32'd0) ? 0 : 32);
        check({tag, "_done"}, done, 1);
        r = model(o, a, b, s);
        hi_m = r[63:32];
        lo_m = r[31:0];
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic move_to(input logic [1:0] o, input logic [31:0] v, input string tag);
        @(negedge clk);
        issue(o, v, 32'd0, 1'b0);
        if (o == 2'd2) hi_m = v; else lo_m = v;
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic        rs;

        repeat (2) @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        move_to(2'd3, 32'hAAAA_5555, "mtlo_pre");
        move_to(2'd2, 32'h5555_AAAA, "mthi_pre");
        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
        repeat (9) @(negedge clk);
        check("midrun_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_hi", hi, 0);
        check("rst_async_lo", lo, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        rst = 1'b0;

        move_to(2'd2, 32'h1234_5678, "mthi");
        idle_check("mthi_after");

        // Largest unsigned product.
        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max", 0);
        check("mul_max_hi_const", hi, 32'hFFFF_FFFE);
        check("mul_max_lo_const", lo, 32'h0000_0001);
        idle_check("mul_max");

        // Division with an MTLO attempted while busy.
        @(negedge clk);
        issue(2'd1, 32'd100, 32'd7, 1'b0);
        finish_op(2'd1, 32'd100, 32'd7, 1'b0, "div_100_7", 5);
        check("div_lo_const", lo, 32'd14);
        check("div_hi_const", hi, 32'd2);
        idle_check("div_100_7");

        // Divide by zero finishes without iterating.
        @(negedge clk);
        issue(2'd1, 32'hDEAD_BEEF, 32'd0, 1'b0);
        finish_op(2'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, "div0", 0);
        check("div0_lo_const", lo, 32'hFFFF_FFFF);
        check("div0_hi_const", hi, 32'hDEAD_BEEF);
        idle_check("div0");

        // Back-to-back: a multiply accepted in the FINISH cycle of a divide.
        @(negedge clk);
        issue(2'd1, 32'd200, 32'd9, 1'b0);
        finish_op(2'd1, 32'd200, 32'd9, 1'b0, "b2b_div", 0);
        issue(2'd0, 32'd3, 32'd5, 1'b0);
        check("b2b_done_drop", done, 0);
        check("b2b_busy_rise", busy, 1);
        check("b2b_div_visible_lo", lo, 32'd22);
        finish_op(2'd0, 32'd3, 32'd5, 1'b0, "b2b_mul", 0);
        check("b2b_final_hi", hi, 32'd0);
        check("b2b_final_lo", lo, 32'd15);
        idle_check("b2b");

`ifdef SIGNED_MULDIV_EN
        @(negedge clk);
        issue(2'd1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        finish_op(2'd1, 32'hFFFF_FFF9, 32'd2, 1'b1, "sdiv", 0);
        check("sdiv_lo_const", lo, 32'hFFFF_FFFD);
        check("sdiv_hi_const", hi, 32'hFFFF_FFFF);
        idle_check("sdiv");
        @(negedge clk);
        issue(2'd0, 32'hFFFF_FFFD, 32'd4, 1'b1);
        finish_op(2'd0, 32'hFFFF_FFFD, 32'd4, 1'b1, "smul", 0);
        check("smul_hi_const", hi, 32'hFFFF_FFFF);
        check("smul_lo_const", lo, 32'hFFFF_FFF4);
        idle_check("smul");
        @(negedge clk);
        issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "sdiv_ovf", 0);
        idle_check("sdiv_ovf");
`endif

        // Random mix of all four operations.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
`ifdef SIGNED_MULDIV_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            if (ro[1]) begin
                move_to(ro, ra, "rand_mt");
            end else begin
                @(negedge clk);
                issue(ro, ra, rb, rs);
                finish_op(ro, ra, rb, rs, ro[0] ? "rand_div" : "rand_mul", 0);
                idle_check("rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
